// File: rtl/stack.sv
// stack: synchronous LIFO of DEPTH words, WL bits each.
// One push or one pop per clock, registered pop data, FULL/EMPTY decoded
// from the occupancy pointer, registered ERROR for illegal requests.
// Optional build macro: STACK_STICKY_ERROR_EN -- when defined, ERROR latches
// high on the first illegal request and stays high until RST.
module stack #(
    parameter int WL    = 4,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          rReq,
    input  logic          wReq,
    input  logic [WL-1:0] din,
    output logic [WL-1:0] dout,
    output logic          FULL,
    output logic          EMPTY,
    output logic          ERROR
);

    // Address width indexes DEPTH words; pointer needs one extra bit to hold DEPTH.
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH) + 1;

    logic [SPW-1:0] r_sp;
    logic [WL-1:0]  r_mem [DEPTH];
    logic [WL-1:0]  r_dout;
    logic           r_error;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_illegal;
    logic [AW-1:0]  w_wr_addr;
    logic [AW-1:0]  w_rd_addr;

    // Request decode: legal push/pop, misuse detection and memory addresses.
    always_comb begin
        w_full    = (r_sp == SPW'(DEPTH));
        w_empty   = (r_sp == '0);
        w_push    = wReq & ~rReq & ~w_full;
        w_pop     = rReq & ~wReq & ~w_empty;
        w_illegal = (wReq & rReq) | (wReq & w_full) | (rReq & w_empty);
        w_wr_addr = AW'(r_sp);
        w_rd_addr = AW'(r_sp - SPW'(1));
    end

    // Occupancy pointer: moves only on a legal push or pop, never wraps.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sp <= '0;
        end else if (w_push) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_pop) begin
            r_sp <= r_sp - SPW'(1);
        end
    end

    // Storage array: written on a legal push; no reset since contents are don't-care.
    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    // Pop data register: captures the top word on a legal pop, otherwise holds.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dout <= '0;
        end else if (w_pop) begin
            r_dout <= r_mem[w_rd_addr];
        end
    end

    // Error flag: per-cycle by default, latched until reset in the sticky build.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_error <= 1'b0;
        end else begin
`ifdef STACK_STICKY_ERROR_EN
            r_error <= r_error | w_illegal;
`else
            r_error <= w_illegal;
`endif
        end
    end

    assign dout  = r_dout;
    assign FULL  = w_full;
    assign EMPTY = w_empty;
    assign ERROR = r_error;

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack: directed test-plan sequence plus randomized
// traffic compared against a queue-based LIFO model.
module tb_stack;

    localparam int WL    = 4;
    localparam int DEPTH = 4;

    logic          CLK  = 1'b0;
    logic          RST  = 1'b1;
    logic          rReq = 1'b0;
    logic          wReq = 1'b0;
    logic [WL-1:0] din  = '0;
    logic [WL-1:0] dout;
    logic          FULL;
    logic          EMPTY;
    logic          ERROR;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WL-1:0] q[$];
    logic [WL-1:0] m_dout = '0;
    logic          m_err  = 1'b0;

    stack #(.WL(WL), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .rReq (rReq),
        .wReq (wReq),
        .din  (din),
        .dout (dout),
        .FULL (FULL),
        .EMPTY(EMPTY),
        .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_apply(input bit w, input bit r, input logic [WL-1:0] d);
        bit ill;
        ill = 1'b0;
        if (w && r) begin
            ill = 1'b1;
        end else if (w) begin
            if (q.size() == DEPTH) ill = 1'b1;
            else q.push_back(d);
        end else if (r) begin
            if (q.size() == 0) ill = 1'b1;
            else m_dout = q.pop_back();
        end
`ifdef STACK_STICKY_ERROR_EN
        m_err = m_err | ill;
`else
        m_err = ill;
`endif
    endtask

    // Drive one request across a rising edge and advance the model.
    task automatic cycle(input bit w, input bit r, input logic [WL-1:0] d);
        wReq = w;
        rReq = r;
        din  = d;
        @(posedge CLK);
        #1;
        model_apply(w, r, d);
        wReq = 1'b0;
        rReq = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got dout=%0h F=%b E=%b ERR=%b, want dout=0 F=0 E=1 ERR=0",
                     dout, FULL, EMPTY, ERROR);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, '0);
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
            errors++;
            $display("FAIL reset_idle: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                     dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
        end
    endtask

    task automatic test_plan();
        logic [WL-1:0] pushes [6];
        logic [WL-1:0] pops   [4];
        pushes = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd4};
        pops   = '{4'd3, 4'd4, 4'd2, 4'd1};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, pushes[i]);
            checks++;
            if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
                errors++;
                $display("FAIL plan_push%0d: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                         i, dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
            end
        end
        checks++;
        if (ERROR !== 1'b1 || FULL !== 1'b1) begin
            errors++;
            $display("FAIL plan_overflow: got ERR=%b F=%b, want ERR=1 F=1", ERROR, FULL);
        end
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (dout !== 4'd5 || FULL !== 1'b0) begin
            errors++;
            $display("FAIL plan_pop_top: got dout=%0h F=%b, want dout=5 F=0", dout, FULL);
        end
        cycle(1'b1, 1'b0, 4'd3);
        cycle(1'b1, 1'b0, 4'd1);
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
            errors++;
            $display("FAIL plan_discard: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                     dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if (dout !== pops[i] || dout !== m_dout) begin
                errors++;
                $display("FAIL plan_pop%0d: got dout=%0h, want %0h", i, dout, pops[i]);
            end
        end
        checks++;
        if (EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL plan_empty: got E=%b, want 1", EMPTY);
        end
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (ERROR !== 1'b1 || dout !== 4'd1 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL plan_underflow: got ERR=%b dout=%0h E=%b, want ERR=1 dout=1 E=1", ERROR, dout, EMPTY);
        end
        cycle(1'b1, 1'b0, 4'd2);
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
            errors++;
            $display("FAIL plan_repush: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                     dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
        end
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (dout !== 4'd2 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL plan_repop: got dout=%0h E=%b, want dout=2 E=1", dout, EMPTY);
        end
    endtask

    task automatic test_simultaneous_and_async_reset();
        cycle(1'b1, 1'b0, 4'd9);
        cycle(1'b1, 1'b0, 4'd6);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 4'hc);
        cycle(1'b1, 1'b1, 4'ha);
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}
            || ERROR !== 1'b1 || dout !== 4'd6) begin
            errors++;
            $display("FAIL both_req: got dout=%0h F=%b E=%b ERR=%b, want dout=6 F=0 E=0 ERR=1",
                     dout, FULL, EMPTY, ERROR);
        end
        // Occupancy must still be 2: two pops return c then 9.
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        checks++;
        if (dout !== 4'd9 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL both_req_occupancy: got dout=%0h E=%b, want dout=9 E=1", dout, EMPTY);
        end
        cycle(1'b1, 1'b0, 4'h3);
        cycle(1'b1, 1'b1, 4'h5);
        // Mid-clock asynchronous reset
        #2;
        RST  = 1'b1;
        wReq = 1'b1;
        din  = 4'hf;
        #1;
        checks++;
        if ({dout, FULL, EMPTY, ERROR} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got dout=%0h F=%b E=%b ERR=%b, want dout=0 F=0 E=1 ERR=0",
                     dout, FULL, EMPTY, ERROR);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (EMPTY !== 1'b1 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_req: got E=%b ERR=%b, want E=1 ERR=0", EMPTY, ERROR);
        end
        wReq = 1'b0;
        #2;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, WL'(i + 8));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0);
            checks++;
            if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
                errors++;
                $display("FAIL b2b_pop%0d: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                         i, dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
            end
        end
    endtask

    task automatic test_random();
        bit w, r;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < 45);
            r = ($urandom_range(0, 99) < 45);
            cycle(w, r, WL'($urandom));
            checks++;
            if ({dout, FULL, EMPTY, ERROR} !== {m_dout, 1'(q.size() == DEPTH), 1'(q.size() == 0), m_err}) begin
                errors++;
                $display("FAIL random%0d: got dout=%0h F=%b E=%b ERR=%b, want dout=%0h F=%b E=%b ERR=%b",
                         i, dout, FULL, EMPTY, ERROR, m_dout, q.size() == DEPTH, q.size() == 0, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_simultaneous_and_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack.md
# stack

Parameterized synchronous LIFO (last-in, first-out) buffer of `DEPTH` words, each `WL` bits wide. It accepts one push or one pop per clock, presents popped data on a registered output, and reports full, empty and misuse status. It serves as a generic local storage primitive wherever data must be returned in reverse order of arrival.

## Interface
- `WL`, default 4: word width in bits; must be ≥1.
- `DEPTH`, default 4: capacity in words; must be ≥2. Any integer is allowed, including non-powers of two.
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: reset, asynchronous and active-high.
- `rReq`  in  1: pop request, sampled at the rising edge of `CLK`.
- `wReq`  in  1: push request, sampled at the rising edge of `CLK`.
- `din`  in  WL: data to push; sampled with `wReq`.
- `dout`  out  WL: registered output holding the most recently popped word.
- `FULL`  out  1: high when the occupancy equals `DEPTH`.
- `EMPTY`  out  1: high when the occupancy is 0.
- `ERROR`  out  1: registered flag marking an illegal request.

## Operation
- Internal storage is `DEPTH`×`WL`.
- The stack pointer `sp` (width clog2(DEPTH)+1) holds the occupancy: 0..DEPTH.
- Push when `wReq`=1, `rReq`=0, not full:
  - mem[sp] <= din.
  - sp <= sp+1.
  - ERROR <= 0.
- Pop when `rReq`=1, `wReq`=0, not empty:
  - dout <= mem[sp-1].
  - sp <= sp-1.
  - ERROR <= 0.
- Push while full: word discarded; sp, mem and dout unchanged; ERROR <= 1.
- Pop while empty: sp unchanged; dout holds its last value; ERROR <= 1.
- Both `wReq` and `rReq` high: no operation; sp, mem and dout unchanged; ERROR <= 1.
- Neither request high: idle; all state is held; ERROR <= 0.
- The pointer never wraps. Overflow and underflow are blocked as described above.
- Flag decode: `FULL` = (sp == DEPTH); `EMPTY` = (sp == 0). Both are combinational decodes of the registered `sp`.
- Popped memory locations are not cleared. Their contents are don't-care.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - sp=0, so EMPTY=1 and FULL=0.
  - dout=0.
  - ERROR=0.
  - Memory contents are don't-care.
- Reset mid-operation discards all stored words. A request in the same cycle as reset is ignored.
- Push latency: the word is stored at the sampling edge. FULL and EMPTY reflect the new occupancy immediately after that edge.
- Pop latency: `dout` carries the popped word from the edge that samples `rReq` until the next pop.
- ERROR is asserted for exactly the cycle following each offending edge. It is cleared by the next legal or idle edge, unless the sticky option is enabled (see Configuration).
- There is no handshake or backpressure. The requester must consult FULL and EMPTY before issuing a request.

## Configuration
- Macro: `STACK_STICKY_ERROR_EN`.
- Defined: once set, ERROR remains 1 until `RST` is asserted. Data-path behavior is identical to the default build.
- Undefined (default): ERROR is per-cycle, as specified above.

## Test plan
- Reset, then idle -> EMPTY=1, FULL=0, ERROR=0, dout=0.
- Push 1, 2, 4, 5 -> FULL=1 after the fourth edge, EMPTY=0, ERROR=0. Then push 7 and push 4 -> ERROR=1 on both, FULL stays 1, and contents are unchanged.
- Pop -> dout=5 and FULL=0. Push 3 -> FULL=1. Push 1 -> ERROR=1 and the word is discarded.
- Pop ×4 -> dout=3, 4, 2, 1 on successive cycles, EMPTY=1 after the fourth. A fifth pop -> ERROR=1, dout holds 1.
- Push 2 -> EMPTY=0, ERROR=0. Pop -> dout=2.
- Simultaneous `wReq`=`rReq`=1 with occupancy 2 -> ERROR=1, occupancy and dout unchanged. Assert `RST` asynchronously mid-clock -> EMPTY=1 and dout=0 immediately. With `STACK_STICKY_ERROR_EN` defined, ERROR stays 1 until that reset.
